// File: rtl/trace_packer.sv
// trace_packer: tracer-side companion of the trace buffer memory logger.
// Write side packs 2**NTRACE_I trace lanes per cycle into TRB_WIDTH-bit words
// and offers each completed word once to the logger; read side (streaming
// modes) fetches words from the logger and replays them onto STREAM_O.
// Optional feature: define TRACE_PACKER_OVERFLOW_CNT_EN to enable the
// saturating dropped-word counter on OVERFLOW_CNT_O (otherwise it reads 0).

module trace_packer #(
  parameter int TRB_WIDTH       = 64,
  parameter int TRB_MAX_TRACES  = 32,
  parameter int TRB_NTRACE_BITS = 3
) (
  input  logic                         CLK_I,
  input  logic                         RST_NI,
  input  logic [1:0]                   MODE_I,
  input  logic [TRB_NTRACE_BITS-1:0]   NTRACE_I,
  input  logic [TRB_MAX_TRACES-1:0]    TRACE_I,
  input  logic                         TRG_I,
  input  logic                         TRG_DELAYED_I,
  input  logic                         STORE_PERM_I,
  output logic                         STORE_O,
  output logic [TRB_WIDTH-1:0]         DATA_O,
  output logic [$clog2(TRB_WIDTH)-1:0] EVENT_POS_O,
  output logic                         TRG_EVENT_O,
  output logic                         OVERFLOW_O,
  output logic                         LOAD_REQUEST_O,
  input  logic                         LOAD_GRANT_I,
  input  logic [TRB_WIDTH-1:0]         DATA_I,
  output logic [TRB_MAX_TRACES-1:0]    STREAM_O,
  output logic [15:0]                  OVERFLOW_CNT_O
);

  localparam int POS_W   = $clog2(TRB_WIDTH);
  localparam int CNT_W   = POS_W + 1;
  localparam int MAX_LOG = $clog2(TRB_MAX_TRACES);
  localparam int LOG_W   = (MAX_LOG > 0) ? $clog2(MAX_LOG + 1) : 1;

  // Mode codes shared with the logger; the unused code behaves like trace mode.
  localparam logic [1:0] TRACE_MODE     = 2'd0;
  localparam logic [1:0] R_STREAM_MODE  = 2'd1;
  localparam logic [1:0] RW_STREAM_MODE = 2'd2;
  localparam logic [1:0] RESERVED_MODE  = 2'd3;

  // Write FSM states
  localparam logic [0:0] WR_CAPTURE = 1'b0;
  localparam logic [0:0] WR_DONE    = 1'b1;

  // Read FSM states
  localparam logic [1:0] RD_REQ  = 2'd0;
  localparam logic [1:0] RD_GAP  = 2'd1;
  localparam logic [1:0] RD_HOLD = 2'd2;

  // Configuration, captured once after reset
  logic                      cfg_loaded;
  logic [1:0]                mode_q;
  logic [LOG_W-1:0]          lane_log_q;
  logic [TRB_MAX_TRACES-1:0] lane_mask_q;
  logic [POS_W-1:0]          last_idx_q;

  logic [LOG_W-1:0]          lane_log_n;
  logic [TRB_MAX_TRACES-1:0] lane_mask_n;
  logic [POS_W-1:0]          last_idx_n;

  logic trace_like;
  logic capture_en;
  logic read_en;

  // Write side
  logic [0:0]           wr_state;
  logic [POS_W-1:0]     sample_idx;
  logic [POS_W-1:0]     sample_pos;
  logic [TRB_WIDTH-1:0] pack_q;
  logic [TRB_WIDTH-1:0] pack_next;
  logic [TRB_WIDTH-1:0] lane_word;
  logic [TRB_WIDTH-1:0] stage_q;
  logic [TRB_WIDTH-1:0] data_q;
  logic                 pending_q;
  logic                 sampling;
  logic                 word_done;
  logic                 word_drop;
  logic                 trg_event_q;
  logic [POS_W-1:0]     event_pos_q;
  logic                 overflow_q;

  // Read side
  logic [1:0]                rd_state;
  logic [TRB_WIDTH-1:0]      sh_q;
  logic [CNT_W-1:0]          sh_cnt_q;
  logic [TRB_WIDTH-1:0]      pf_q;
  logic                      pf_valid_q;
  logic                      consume;
  logic                      grant_take;
  logic [POS_W:0]            lane_width;
  logic [TRB_MAX_TRACES-1:0] stream_src;

  // Derive lane geometry from the requested width, clamping oversize requests
  always_comb begin
    lane_log_n = LOG_W'(MAX_LOG);
    if (int'(NTRACE_I) < MAX_LOG) lane_log_n = LOG_W'(NTRACE_I);
    lane_mask_n = '0;
    for (int i = 0; i < TRB_MAX_TRACES; i++) begin
      if (i < (1 << lane_log_n)) lane_mask_n[i] = 1'b1;
    end
    last_idx_n = POS_W'((TRB_WIDTH >> lane_log_n) - 1);
  end

  // Latch mode and lane geometry on the first clock after reset, then hold
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      cfg_loaded  <= 1'b0;
      mode_q      <= TRACE_MODE;
      lane_log_q  <= '0;
      lane_mask_q <= '0;
      last_idx_q  <= '0;
    end else if (!cfg_loaded) begin
      cfg_loaded  <= 1'b1;
      mode_q      <= MODE_I;
      lane_log_q  <= lane_log_n;
      lane_mask_q <= lane_mask_n;
      last_idx_q  <= last_idx_n;
    end
  end

  assign trace_like = cfg_loaded && (mode_q == TRACE_MODE || mode_q == RESERVED_MODE);
  assign capture_en = cfg_loaded && (mode_q != R_STREAM_MODE);
  assign read_en    = cfg_loaded && (mode_q == R_STREAM_MODE || mode_q == RW_STREAM_MODE);

  assign sampling   = capture_en && (wr_state == WR_CAPTURE);
  assign word_done  = sampling && (sample_idx == last_idx_q);
  assign sample_pos = sample_idx << lane_log_q;
  assign lane_word  = TRB_WIDTH'(TRACE_I & lane_mask_q);
  assign pack_next  = ((sample_idx == '0) ? '0 : pack_q) | (lane_word << sample_pos);

  // Pack samples into the current word and hand completed words to the stage register
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      wr_state   <= WR_CAPTURE;
      sample_idx <= '0;
      pack_q     <= '0;
      stage_q    <= '0;
      pending_q  <= 1'b0;
    end else begin
      pending_q <= word_done;
      if (word_done) stage_q <= pack_next;
      if (sampling) begin
        pack_q     <= pack_next;
        sample_idx <= word_done ? '0 : sample_idx + POS_W'(1);
        if (trace_like && TRG_DELAYED_I) wr_state <= WR_DONE;
      end
    end
  end

  assign STORE_O   = pending_q && STORE_PERM_I;
  assign word_drop = pending_q && !STORE_PERM_I;
  assign DATA_O    = STORE_O ? stage_q : data_q;

  // Remember the last word the logger accepted and flag any dropped word
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (STORE_O) data_q <= stage_q;
      if (word_drop) overflow_q <= 1'b1;
    end
  end

  // Record the position of the first trigger only
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      trg_event_q <= 1'b0;
      event_pos_q <= '0;
    end else if (sampling && TRG_I && !trg_event_q) begin
      trg_event_q <= 1'b1;
      event_pos_q <= sample_pos;
    end
  end

  assign TRG_EVENT_O = trg_event_q;
  assign EVENT_POS_O = event_pos_q;
  assign OVERFLOW_O  = overflow_q;

`ifdef TRACE_PACKER_OVERFLOW_CNT_EN
  logic [15:0] ovf_cnt_q;

  // Count dropped words, sticking at the maximum
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      ovf_cnt_q <= '0;
    end else if (word_drop && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign OVERFLOW_CNT_O = ovf_cnt_q;
`else
  assign OVERFLOW_CNT_O = '0;
`endif

  assign lane_width = (POS_W+1)'(1) << lane_log_q;
  assign consume    = read_en && (sh_cnt_q == '0) && pf_valid_q;
  assign grant_take = read_en && (rd_state == RD_REQ) && LOAD_GRANT_I;

  // The live lane comes from the shift buffer, or straight from prefetch when
  // the shift buffer just ran dry, so consecutive words stream without a gap
  always_comb begin
    stream_src = '0;
    if (sh_cnt_q != '0) stream_src = sh_q[TRB_MAX_TRACES-1:0];
    else if (pf_valid_q) stream_src = pf_q[TRB_MAX_TRACES-1:0];
  end

  assign STREAM_O       = stream_src & lane_mask_q;
  assign LOAD_REQUEST_O = read_en && (rd_state == RD_REQ);

  // Shift/prefetch buffers and the request handshake with the logger
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      rd_state   <= RD_REQ;
      sh_q       <= '0;
      sh_cnt_q   <= '0;
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
    end else begin
      if (consume) begin
        sh_q       <= pf_q >> lane_width;
        sh_cnt_q   <= CNT_W'(last_idx_q);
        pf_valid_q <= 1'b0;
      end else if (sh_cnt_q != '0) begin
        sh_q     <= sh_q >> lane_width;
        sh_cnt_q <= sh_cnt_q - CNT_W'(1);
      end
      if (grant_take) begin
        pf_q       <= DATA_I;
        pf_valid_q <= 1'b1;
      end
      case (rd_state)
        RD_REQ:  if (grant_take) rd_state <= RD_GAP;
        RD_GAP:  rd_state <= (pf_valid_q && !consume) ? RD_HOLD : RD_REQ;
        RD_HOLD: if (consume) rd_state <= RD_REQ;
        default: rd_state <= RD_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_packer.sv
// tb_trace_packer: directed test of trace_packer. Stimulus pushes expected
// stored words and stream lanes into queues; a monitor on the falling edge
// pops and compares whenever the DUT presents a store or a streamed lane.

module tb_trace_packer;

  logic        CLK_I = 1'b0;
  logic        RST_NI = 1'b0;
  logic [1:0]  MODE_I = 2'd0;
  logic [2:0]  NTRACE_I = 3'd0;
  logic [31:0] TRACE_I = '0;
  logic        TRG_I = 1'b0;
  logic        TRG_DELAYED_I = 1'b0;
  logic        STORE_PERM_I = 1'b0;
  logic        STORE_O;
  logic [63:0] DATA_O;
  logic [5:0]  EVENT_POS_O;
  logic        TRG_EVENT_O;
  logic        OVERFLOW_O;
  logic        LOAD_REQUEST_O;
  logic        LOAD_GRANT_I = 1'b0;
  logic [63:0] DATA_I = '0;
  logic [31:0] STREAM_O;
  logic [15:0] OVERFLOW_CNT_O;

  logic [63:0] store_q[$];
  logic [31:0] stream_q[$];
  logic [63:0] mon_exp;
  logic [31:0] mon_lane;
  int errors = 0;
  int checks = 0;

  trace_packer dut (
    .CLK_I(CLK_I), .RST_NI(RST_NI), .MODE_I(MODE_I), .NTRACE_I(NTRACE_I),
    .TRACE_I(TRACE_I), .TRG_I(TRG_I), .TRG_DELAYED_I(TRG_DELAYED_I),
    .STORE_PERM_I(STORE_PERM_I), .STORE_O(STORE_O), .DATA_O(DATA_O),
    .EVENT_POS_O(EVENT_POS_O), .TRG_EVENT_O(TRG_EVENT_O), .OVERFLOW_O(OVERFLOW_O),
    .LOAD_REQUEST_O(LOAD_REQUEST_O), .LOAD_GRANT_I(LOAD_GRANT_I), .DATA_I(DATA_I),
    .STREAM_O(STREAM_O), .OVERFLOW_CNT_O(OVERFLOW_CNT_O)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] trace, input logic trg, input logic trg_del, input logic perm);
    TRACE_I       = trace;
    TRG_I         = trg;
    TRG_DELAYED_I = trg_del;
    STORE_PERM_I  = perm;
    tick();
  endtask

  task automatic doReset(input logic [1:0] mode, input logic [2:0] ntrace);
    RST_NI        = 1'b0;
    TRACE_I       = '0;
    TRG_I         = 1'b0;
    TRG_DELAYED_I = 1'b0;
    STORE_PERM_I  = 1'b1;
    LOAD_GRANT_I  = 1'b0;
    DATA_I        = '0;
    tick();
    tick();
    MODE_I   = mode;
    NTRACE_I = ntrace;
    RST_NI   = 1'b1;
    tick();
  endtask

  // Scoreboard monitor: compare every store strobe and every expected lane
  always @(negedge CLK_I) begin
    if (STORE_O) begin
      if (store_q.size() == 0) begin
        checkOutput("unexpected_store", 64'(STORE_O), 64'd0);
      end else begin
        mon_exp = store_q.pop_front();
        checkOutput("store_data", DATA_O, mon_exp);
      end
    end
    if (stream_q.size() != 0) begin
      mon_lane = stream_q.pop_front();
      checkOutput("stream_lane", 64'(STREAM_O), 64'(mon_lane));
    end
  end

  initial begin
    logic [31:0] s0 [4];
    logic [31:0] s1 [4];
    logic        perm [4];

    // Reset values, with a streaming mode requested during reset
    RST_NI = 1'b0;
    MODE_I = 2'd1;
    tick();
    checkOutput("reset_store", 64'(STORE_O), 64'd0);
    checkOutput("reset_data", DATA_O, 64'd0);
    checkOutput("reset_flags", 64'({TRG_EVENT_O, OVERFLOW_O, LOAD_REQUEST_O}), 64'd0);
    checkOutput("reset_pos_stream", 64'({EVENT_POS_O, STREAM_O}), 64'd0);
    checkOutput("reset_ovf_cnt", 64'(OVERFLOW_CNT_O), 64'd0);

    // 1-lane toggling pattern
    $display("[TB] trace_mode W=1 toggle");
    doReset(2'd0, 3'd0);
    store_q.push_back(64'h5555_5555_5555_5555);
    for (int k = 0; k < 64; k++) applyStimulus((k % 2 == 0) ? 32'd1 : 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("t1_store_q_empty", 64'(store_q.size()), 64'd0);

    // 4 lanes, upper input bits must be ignored; reserved mode code acts as trace
    $display("[TB] reserved mode W=4 two words");
    doReset(2'd3, 3'd2);
    store_q.push_back(64'hAAAA_AAAA_AAAA_AAAA);
    store_q.push_back(64'h3333_3333_3333_3333);
    for (int k = 0; k < 16; k++) applyStimulus(32'hFFFF_FFFA, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) applyStimulus(32'h1234_5673, 1'b0, 1'b0, 1'b1);
    checkOutput("t2_no_request", 64'(LOAD_REQUEST_O), 64'd0);
    tick();
    checkOutput("t2_store_q_empty", 64'(store_q.size()), 64'd0);

    // Trigger position, later trigger ignored, delayed trigger ends capture
    $display("[TB] trigger and end of trace");
    doReset(2'd0, 3'd0);
    store_q.push_back(64'h0000_0000_FFFF_FFFF);
    for (int k = 0; k < 64; k++) begin
      applyStimulus((k < 32) ? 32'd1 : 32'd0, (k == 10 || k == 20), (k == 63), 1'b1);
      if (k == 9) checkOutput("t3_no_trg_yet", 64'(TRG_EVENT_O), 64'd0);
      if (k == 10) checkOutput("t3_event_pos", 64'(EVENT_POS_O), 64'd10);
      if (k == 10) checkOutput("t3_trg_event", 64'(TRG_EVENT_O), 64'd1);
      if (k == 20) checkOutput("t3_pos_held", 64'(EVENT_POS_O), 64'd10);
    end
    for (int k = 0; k < 70; k++) applyStimulus(32'd1, 1'b1, 1'b0, 1'b1);
    checkOutput("t3_store_q_empty", 64'(store_q.size()), 64'd0);
    checkOutput("t3_pos_final", 64'(EVENT_POS_O), 64'd10);

    // Dropped words with oversize lane request (clamps to 32 lanes)
    $display("[TB] overflow W=32");
    doReset(2'd0, 3'd6);
    s0[0] = 32'h1111_2222; s1[0] = 32'h3333_4444; perm[0] = 1'b1;
    s0[1] = 32'hDEAD_BEEF; s1[1] = 32'h0BAD_F00D; perm[1] = 1'b0;
    s0[2] = 32'h1234_5678; s1[2] = 32'h9ABC_DEF0; perm[2] = 1'b0;
    s0[3] = 32'hCAFE_0001; s1[3] = 32'h0000_0002; perm[3] = 1'b1;
    store_q.push_back(64'h3333_4444_1111_2222);
    store_q.push_back(64'h0000_0002_CAFE_0001);
    for (int w = 0; w < 4; w++) begin
      applyStimulus(s0[w], 1'b0, 1'b0, (w == 0) ? 1'b1 : perm[w-1]);
      if (w == 1) checkOutput("t4_no_overflow", 64'(OVERFLOW_O), 64'd0);
      if (w == 2) checkOutput("t4_overflow", 64'(OVERFLOW_O), 64'd1);
      if (w == 2) checkOutput("t4_data_held", DATA_O, 64'h3333_4444_1111_2222);
      applyStimulus(s1[w], 1'b0, 1'b0, (w == 0) ? 1'b1 : perm[w-1]);
    end
    applyStimulus(32'd0, 1'b0, 1'b0, perm[3]);
`ifdef TRACE_PACKER_OVERFLOW_CNT_EN
    checkOutput("t4_ovf_cnt", 64'(OVERFLOW_CNT_O), 64'd2);
`else
    checkOutput("t4_ovf_cnt", 64'(OVERFLOW_CNT_O), 64'd0);
`endif
    checkOutput("t4_store_q_empty", 64'(store_q.size()), 64'd0);

    // Read streaming, 8 lanes, two back-to-back words then underflow
    $display("[TB] r_stream_mode W=8");
    doReset(2'd1, 3'd3);
    checkOutput("t5_req_initial", 64'(LOAD_REQUEST_O), 64'd1);
    checkOutput("t5_underflow_start", 64'(STREAM_O), 64'd0);
    LOAD_GRANT_I = 1'b1;
    DATA_I = 64'h0807_0605_0403_0201;
    tick();
    LOAD_GRANT_I = 1'b0;
    for (int b = 1; b <= 16; b++) stream_q.push_back(32'(b));
    stream_q.push_back(32'd0);
    checkOutput("t5_req_gap", 64'(LOAD_REQUEST_O), 64'd0);
    tick();
    checkOutput("t5_req_rearm", 64'(LOAD_REQUEST_O), 64'd1);
    LOAD_GRANT_I = 1'b1;
    DATA_I = 64'h100F_0E0D_0C0B_0A09;
    tick();
    LOAD_GRANT_I = 1'b0;
    checkOutput("t5_req_gap2", 64'(LOAD_REQUEST_O), 64'd0);
    tick();
    checkOutput("t5_req_hold", 64'(LOAD_REQUEST_O), 64'd0);
    for (int k = 0; k < 16; k++) tick();
    checkOutput("t5_stream_q_empty", 64'(stream_q.size()), 64'd0);
    checkOutput("t5_req_final", 64'(LOAD_REQUEST_O), 64'd1);

    // Reset in the middle of a word discards the partial word
    $display("[TB] reset mid-word");
    doReset(2'd0, 3'd0);
    for (int k = 0; k < 5; k++) applyStimulus(32'd1, (k == 2), 1'b0, 1'b1);
    checkOutput("t6_trg_before", 64'({TRG_EVENT_O, EVENT_POS_O}), 64'({1'b1, 6'd2}));
    RST_NI = 1'b0;
    #1;
    checkOutput("t6_reset_flags", 64'({TRG_EVENT_O, EVENT_POS_O, STORE_O, OVERFLOW_O}), 64'd0);
    doReset(2'd0, 3'd0);
    store_q.push_back(64'h0000_0000_0000_000F);
    for (int k = 0; k < 64; k++) applyStimulus((k < 4) ? 32'd1 : 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("t6_store_q_empty", 64'(store_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
